// File: rtl/axis_header_strip.sv
// Strips a variable-length header (0..DATA_BYTE_WD bytes) from the first beat of each packet,
// emits it right-aligned on m00 and re-packs the remaining bytes into full MSB-aligned beats on m01.
module axis_header_strip #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s00_axis_tvalid,
    input  logic [LEN_WD-1:0]       s00_axis_tdata,
    output logic                    s00_axis_tready,
    input  logic                    s01_axis_tvalid,
    input  logic [DATA_WD-1:0]      s01_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic                    m00_axis_tvalid,
    output logic [DATA_WD-1:0]      m00_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m00_axis_tkeep,
    input  logic                    m00_axis_tready,
    output logic                    m01_axis_tvalid,
    output logic [DATA_WD-1:0]      m01_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m01_axis_tkeep,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    output logic                    err_short
);

    // One extra bit so residual + new byte counts (up to 2*DATA_BYTE_WD-1) never overflow.
    localparam int               CNT_WD = LEN_WD + 1;
    localparam logic [CNT_WD-1:0] BW    = CNT_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

    state_t                  state_reg;
    logic [CNT_WD-1:0]       len_reg;
    logic [DATA_WD-1:0]      res_data_reg;
    logic [CNT_WD-1:0]       res_cnt_reg;
    logic                    m00_valid_reg;
    logic [DATA_WD-1:0]      m00_data_reg;
    logic [DATA_BYTE_WD-1:0] m00_keep_reg;
    logic                    m01_valid_reg;
    logic [DATA_WD-1:0]      m01_data_reg;
    logic [DATA_BYTE_WD-1:0] m01_keep_reg;
    logic                    m01_last_reg;
    logic                    err_short_reg;

    logic [DATA_WD-1:0]      in_mask;
    logic [DATA_WD-1:0]      in_data;
    logic [CNT_WD-1:0]       in_cnt;
    logic [CNT_WD-1:0]       len_in;
    logic                    hdr_phase;
    logic                    hdr_short;
    logic [CNT_WD-1:0]       hdr_cnt;
    logic [CNT_WD-1:0]       hdr_shift;
    logic [DATA_WD-1:0]      hdr_data;
    logic [DATA_BYTE_WD-1:0] hdr_keep;
    logic [DATA_WD-1:0]      cur_res_data;
    logic [CNT_WD-1:0]       cur_res_cnt;
    logic [DATA_WD-1:0]      new_data;
    logic [CNT_WD-1:0]       new_cnt;
    logic [CNT_WD-1:0]       total;
    logic [2*DATA_WD-1:0]    merged;
    logic [DATA_WD-1:0]      merged_hi;
    logic [DATA_WD-1:0]      merged_lo;
    logic                    full;
    logic                    m00_free;
    logic                    m01_free;
    logic                    s01_fire;

    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input logic [CNT_WD-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    // Bytes outside tkeep are forced to zero so they can never leak into merged beats.
    generate
        for (genvar gi = 0; gi < DATA_BYTE_WD; gi++) begin : g_mask
            assign in_mask[gi*8 +: 8] = {8{s01_axis_tkeep[gi]}};
        end
    endgenerate
    assign in_data = s01_axis_tdata & in_mask;

    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            in_cnt = in_cnt + CNT_WD'(s01_axis_tkeep[i]);
        end
    end

    assign len_in    = CNT_WD'(s00_axis_tdata);
    assign hdr_phase = (state_reg == HDR);
    assign hdr_short = (in_cnt < len_reg);
    assign hdr_cnt   = hdr_short ? in_cnt : len_reg;
    assign hdr_shift = BW - hdr_cnt;
    assign hdr_data  = in_data >> {hdr_shift, 3'b000};
    assign hdr_keep  = ~({DATA_BYTE_WD{1'b1}} << hdr_cnt);

    // The first beat is treated as a body beat with an empty residual once the header is cut off.
    assign cur_res_data = hdr_phase ? '0 : res_data_reg;
    assign cur_res_cnt  = hdr_phase ? '0 : res_cnt_reg;
    assign new_data     = hdr_phase ? (in_data << {len_reg, 3'b000}) : in_data;
    assign new_cnt      = hdr_phase ? (hdr_short ? '0 : in_cnt - len_reg) : in_cnt;
    assign total        = cur_res_cnt + new_cnt;
    assign merged       = {cur_res_data, {DATA_WD{1'b0}}}
                        | ({new_data, {DATA_WD{1'b0}}} >> {cur_res_cnt, 3'b000});
    assign merged_hi    = merged[2*DATA_WD-1:DATA_WD];
    assign merged_lo    = merged[DATA_WD-1:0];
    assign full         = (total >= BW);

    assign m00_free = !m00_valid_reg || m00_axis_tready;
    assign m01_free = !m01_valid_reg || m01_axis_tready;

    assign s00_axis_tready = (state_reg == IDLE);
    assign s01_axis_tready = (hdr_phase && m00_free && m01_free)
                          || ((state_reg == BODY) && m01_free);
    assign s01_fire        = s01_axis_tvalid && s01_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            res_data_reg  <= '0;
            res_cnt_reg   <= '0;
            m00_valid_reg <= 1'b0;
            m00_data_reg  <= '0;
            m00_keep_reg  <= '0;
            m01_valid_reg <= 1'b0;
            m01_data_reg  <= '0;
            m01_keep_reg  <= '0;
            m01_last_reg  <= 1'b0;
            err_short_reg <= 1'b0;
        end else begin
            err_short_reg <= 1'b0;
            if (m00_valid_reg && m00_axis_tready) m00_valid_reg <= 1'b0;
            if (m01_valid_reg && m01_axis_tready) m01_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (s00_axis_tvalid) begin
                        len_reg   <= (len_in > BW) ? BW : len_in;
                        state_reg <= HDR;
                    end
                end
                HDR, BODY: begin
                    if (s01_fire) begin
                        if (hdr_phase && len_reg != '0) begin
                            m00_valid_reg <= 1'b1;
                            m00_data_reg  <= hdr_data;
                            m00_keep_reg  <= hdr_keep;
                        end
                        if (hdr_phase && hdr_short && s01_axis_tlast) err_short_reg <= 1'b1;

                        res_data_reg <= full ? merged_lo : merged_hi;
                        res_cnt_reg  <= full ? total - BW : total;

                        if (s01_axis_tlast) begin
                            if (total > BW) begin
                                m01_valid_reg <= 1'b1;
                                m01_data_reg  <= merged_hi;
                                m01_keep_reg  <= '1;
                                m01_last_reg  <= 1'b0;
                                state_reg     <= FLUSH;
                            end else begin
                                if (total != '0) begin
                                    m01_valid_reg <= 1'b1;
                                    m01_data_reg  <= merged_hi;
                                    m01_keep_reg  <= keep_top(total);
                                    m01_last_reg  <= 1'b1;
                                end
                                res_data_reg <= '0;
                                res_cnt_reg  <= '0;
                                state_reg    <= IDLE;
                            end
                        end else begin
                            if (full) begin
                                m01_valid_reg <= 1'b1;
                                m01_data_reg  <= merged_hi;
                                m01_keep_reg  <= '1;
                                m01_last_reg  <= 1'b0;
                            end
                            state_reg <= BODY;
                        end
                    end
                end
                FLUSH: begin
                    if (m01_free) begin
                        m01_valid_reg <= 1'b1;
                        m01_data_reg  <= res_data_reg;
                        m01_keep_reg  <= keep_top(res_cnt_reg);
                        m01_last_reg  <= 1'b1;
                        res_data_reg  <= '0;
                        res_cnt_reg   <= '0;
                        state_reg     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign m00_axis_tvalid = m00_valid_reg;
    assign m00_axis_tdata  = m00_data_reg;
    assign m00_axis_tkeep  = m00_keep_reg;
    assign m01_axis_tvalid = m01_valid_reg;
    assign m01_axis_tdata  = m01_data_reg;
    assign m01_axis_tkeep  = m01_keep_reg;
    assign m01_axis_tlast  = m01_last_reg;
    assign err_short       = err_short_reg;

endmodule
